// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch stage.
// Holds the fetch PC and issues word-aligned requests to instruction memory.
// Accepts in-order responses and buffers {pc, instruction} pairs for decode.
// Redirects discard buffered entries and any responses still in flight.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req_*        request channel (valid/ready/addr); valid is not sticky
//   imem_rsp_*        in-order response channel; no backpressure
//   redirect_valid/pc taken-branch/jump redirect; pc[1:0] ignored
//   if_valid/ready    handshake towards decode
//   if_instruction/pc head buffer entry
module if_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     if_instruction,
   output logic [XLEN-1:0] if_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [XLEN-1:0] pc_mem  [DEPTH];
   logic [31:0]     ins_mem [DEPTH];

   logic            req_fire;
   logic            rsp_ok;
   logic            push;
   logic            pop;
   logic [SW-1:0]   credit_used;
   logic [XLEN-1:0] redirect_base;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Credit check covers in-flight plus buffered, so every response has a slot.
   // A response with nothing outstanding is a protocol violation and is ignored.
   always_comb begin
      credit_used    = SW'(outstanding) + SW'(count);
      imem_req_valid = !rst && !redirect_valid && (credit_used < SW'(DEPTH));
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_ok         = imem_rsp_valid && (outstanding != '0);
      push           = rsp_ok && (drop_cnt == '0) && !redirect_valid;
      if_valid       = (count != '0) && !redirect_valid;
      pop            = if_valid && if_ready;
      redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
   end

   assign imem_req_addr  = fetch_pc;
   assign if_instruction = ins_mem[rd_ptr];
   assign if_pc          = pc_mem[rd_ptr];

   // Control state; redirect wins over issue, response push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc    <= redirect_base;
         rsp_pc      <= redirect_base;
         outstanding <= outstanding - CW'(rsp_ok);
         drop_cnt    <= outstanding - CW'(rsp_ok);
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
         if (rsp_ok && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (push) begin
            rsp_pc <= rsp_pc + XLEN'(4);
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Buffer storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         pc_mem[wr_ptr]  <= rsp_pc;
         ins_mem[wr_ptr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized-latency checks for if_stage.
// The bench owns the instruction memory model and an architectural PC model.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instruction (if_instruction),
      .if_pc          (if_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pending [$];
   logic [31:0] pop_log [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          pops     = 0;
   int          lat_lo   = 1;
   int          lat_hi   = 1;
   int          rdy_mode = 0;
   bit          ifr_rand = 1'b0;
   bit          ifr_hold = 1'b1;
   int          mout, mdrop, mcount, last_due;
   logic [31:0] mfetch, exp_pc;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Two reset edges; memory model is reset together with the core.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      pending.delete();
      mout = 0; mdrop = 0; mcount = 0; last_due = 0; cyc = 0;
      mfetch = 32'h0; exp_pc = 32'h0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_if_valid",  32'(if_valid),       32'h0);
      chk("rst_req_addr",  imem_req_addr,       32'h0);
      @(posedge clk);
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance model.
   task automatic step(input bit redir, input logic [31:0] rpc);
      bit          rsp, exp_req, exp_v;
      int          due;
      req_t        r;
      @(negedge clk);
      rst = 1'b0;
      cyc++;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if_ready       = ifr_rand ? ($urandom_range(1, 0) == 1) : ifr_hold;
      case (rdy_mode)
         0:       imem_req_ready = 1'b1;
         1:       imem_req_ready = ($urandom_range(3, 0) != 0);
         default: imem_req_ready = 1'b0;
      endcase
      rsp = 1'b0;
      imem_rsp_data = 32'h0;
      if (pending.size() != 0 && pending[0].due <= cyc) begin
         rsp = 1'b1;
         imem_rsp_data = word(pending[0].addr);
         void'(pending.pop_front());
      end
      imem_rsp_valid = rsp;
      #1;
      assert (!(rsp && mout == 0)) else $error("imem response with no outstanding request");
      exp_req = !redir && (mout + mcount < 4);
      exp_v   = (mcount != 0) && !redir;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      chk("req_addr",  imem_req_addr,       mfetch);
      chk("if_valid",  32'(if_valid),       32'(exp_v));
      if (exp_v) begin
         chk("if_pc",    if_pc,          exp_pc);
         chk("if_instr", if_instruction, word(exp_pc));
      end
      if (redir) begin
         if (rsp) mout--;
         mdrop  = mout;
         mcount = 0;
         mfetch = {rpc[31:2], 2'b00};
         exp_pc = mfetch;
      end else begin
         if (exp_req && imem_req_ready) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = mfetch;
            r.due  = due;
            pending.push_back(r);
            mfetch += 32'd4;
            mout++;
         end
         if (rsp) begin
            mout--;
            if (mdrop > 0) mdrop--;
            else mcount++;
         end
         if (exp_v && if_ready) begin
            pop_log.push_back(exp_pc);
            exp_pc += 32'd4;
            mcount--;
            pops++;
         end
      end
   endtask

   initial begin
      int p0;
      rst = 1'b1;
      do_reset();

      // Streaming with 1-cycle memory and decode always ready.
      lat_lo = 1; lat_hi = 1; rdy_mode = 0; ifr_rand = 1'b0; ifr_hold = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 32'h0);
         if (cyc <= 4) chk("stream_addr", imem_req_addr, 32'(4 * (cyc - 1)));
         if (cyc == 2) chk("stream_if_valid_c2", 32'(if_valid), 32'h0);
         if (cyc == 3) chk("stream_if_valid_c3", 32'(if_valid), 32'h1);
         if (cyc == 8) chk("stream_pops_c8", 32'(pops), 32'd6);
      end

      // Decode backpressure saturates the credit, then drains in order.
      ifr_hold = 1'b0;
      repeat (10) step(1'b0, 32'h0);
      chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
      chk("bp_if_valid",  32'(if_valid),       32'h1);
      ifr_hold = 1'b1;
      p0 = pops;
      repeat (4) step(1'b0, 32'h0);
      chk("bp_drain", 32'(pops - p0), 32'd4);

      // Redirect with exactly two requests in flight and no response that cycle.
      lat_lo = 4; lat_hi = 4; rdy_mode = 2;
      repeat (8) step(1'b0, 32'h0);
      rdy_mode = 0;
      repeat (2) step(1'b0, 32'h0);
      pop_log.delete();
      step(1'b1, 32'h100);
      chk("redir_req_valid", 32'(imem_req_valid), 32'h0);
      chk("redir_if_valid",  32'(if_valid),       32'h0);
      lat_lo = 1; lat_hi = 1;
      step(1'b0, 32'h0);
      chk("redir_new_addr", imem_req_addr, 32'h100);
      repeat (12) step(1'b0, 32'h0);
      chk("redir_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

      // Redirect coinciding with a response and a would-be pop.
      repeat (6) step(1'b0, 32'h0);
      pop_log.delete();
      step(1'b1, 32'h180);
      step(1'b0, 32'h0);
      chk("coinc_if_valid", 32'(if_valid), 32'h0);
      repeat (6) step(1'b0, 32'h0);
      chk("coinc_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h180);

      // Misaligned redirect target.
      step(1'b1, 32'h203);
      step(1'b0, 32'h0);
      chk("misalign_addr", imem_req_addr, 32'h200);
      repeat (6) step(1'b0, 32'h0);

      // Redirect to the top of the address space wraps to zero.
      pop_log.delete();
      step(1'b1, 32'hFFFF_FFFC);
      step(1'b0, 32'h0);
      chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
      step(1'b0, 32'h0);
      chk("wrap_addr1", imem_req_addr, 32'h0000_0000);
      repeat (8) step(1'b0, 32'h0);
      chk("wrap_pop0", pop_log.size() > 1 ? pop_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      chk("wrap_pop1", pop_log.size() > 1 ? pop_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

      // Reset in the middle of traffic.
      lat_lo = 3; lat_hi = 3; rdy_mode = 1;
      repeat (7) step(1'b0, 32'h0);
      do_reset();
      lat_lo = 1; lat_hi = 1; rdy_mode = 0;
      step(1'b0, 32'h0);
      chk("postrst_addr", imem_req_addr, 32'h0);
      repeat (6) step(1'b0, 32'h0);

      // Random latency, ready and decode stalls with periodic redirects.
      lat_lo = 1; lat_hi = 5; rdy_mode = 1; ifr_rand = 1'b1;
      p0 = pops;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(19, 0) == 0) step(1'b1, $urandom());
         else                            step(1'b0, 32'h0);
      end
      chk("rand_progress", 32'(pops - p0 > 100), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
